// File: rtl/hdmi_packet_assembler.sv
// HDMI data-island packet assembler.
//
// Serialises one packet (24-bit header + four 56-bit subpackets) over 32 pixel clocks into the
// 9 per-cycle data-island bits feeding the TERC4 encoders, appending BCH(32,24) parity to the
// header and BCH(64,56) parity to each subpacket.
//
// Ports:
//   clk_pixel          pixel clock (only clock)
//   reset_n            asynchronous active-low reset
//   data_island_period high during data-island packet cycles (guard bands excluded)
//   header[23:0]       HB0..HB2, bit 0 emitted first
//   sub[223:0]         subpackets 0..3 packed flat; subpacket i is sub[56*i +: 56], bit 0 first
//   packet_data[8:0]   [0] header/parity, [4:1] even bit of sub0..3, [8:5] odd bit of sub0..3
//   counter[4:0]       slot index of the bits currently on packet_data
//   packet_enable      combinational pulse: inputs are being latched this cycle
//   packet_done        registered pulse on the output cycle carrying slot 31
//   packet_count[15:0] (only with HDMI_PACKET_COUNT_EN) completed-packet counter, wraps
//
// Build option: define HDMI_PACKET_COUNT_EN to add the packet_count output.
module hdmi_packet_assembler #(
  parameter logic [7:0] BCH_POLY = 8'h83
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         data_island_period,
  input  logic [23:0]  header,
  input  logic [223:0] sub,
  output logic [8:0]   packet_data,
  output logic [4:0]   counter,
  output logic         packet_enable,
  output logic         packet_done
`ifdef HDMI_PACKET_COUNT_EN
  ,
  output logic [15:0]  packet_count
`endif
);

  logic [4:0]   slot_q;
  logic [23:0]  hdr_q;
  logic [223:0] sub_q;
  logic [7:0]   ecc_h_q, ecc_h_d;
  logic [31:0]  ecc_s_q, ecc_s_d;
  logic [8:0]   data_q, data_d;
  logic [4:0]   counter_q;
  logic         done_q;

  // Working copies: slot 0 uses the live inputs and a cleared syndrome.
  logic [23:0]  hdr_cur;
  logic [223:0] sub_cur;
  logic [7:0]   ecc_h_cur;
  logic [31:0]  ecc_s_cur;
  logic [5:0]   even_idx;
  logic [2:0]   par_idx;
  logic [55:0]  word;
  logic [7:0]   ecc;
  logic [1:0]   pair;

  // One step of the shift-right BCH LFSR.
  function automatic logic [7:0] bch_step(input logic [7:0] state, input logic b);
    logic fb;
    fb = state[0] ^ b;
    return (state >> 1) ^ (fb ? BCH_POLY : 8'h00);
  endfunction

  assign packet_enable = reset_n & data_island_period & (slot_q == 5'd0);

  always_comb begin
    hdr_cur   = (slot_q == 5'd0) ? header : hdr_q;
    sub_cur   = (slot_q == 5'd0) ? sub : sub_q;
    ecc_h_cur = (slot_q == 5'd0) ? 8'h00 : ecc_h_q;
    ecc_s_cur = (slot_q == 5'd0) ? 32'h0 : ecc_s_q;
    even_idx  = {slot_q, 1'b0};
    // Parity slots 24..31 (header) and 28..31 (subpackets) index via the low slot bits.
    par_idx   = {slot_q[1:0], 1'b0};
    data_d    = '0;
    ecc_h_d   = ecc_h_cur;
    ecc_s_d   = ecc_s_cur;
    word      = '0;
    ecc       = '0;
    pair      = '0;

    if (slot_q < 5'd24) begin
      data_d[0] = hdr_cur[slot_q];
      ecc_h_d   = bch_step(ecc_h_cur, hdr_cur[slot_q]);
    end else begin
      data_d[0] = ecc_h_cur[slot_q[2:0]];
    end

    for (int i = 0; i < 4; i++) begin
      word = sub_cur[56*i +: 56];
      ecc  = ecc_s_cur[8*i +: 8];
      if (slot_q < 5'd28) begin
        pair = word[even_idx +: 2];
        // Even bit first, then odd bit, both in this cycle.
        ecc_s_d[8*i +: 8] = bch_step(bch_step(ecc, pair[0]), pair[1]);
      end else begin
        pair = ecc[par_idx +: 2];
      end
      data_d[1+i] = pair[0];
      data_d[5+i] = pair[1];
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= '0;
      hdr_q     <= '0;
      sub_q     <= '0;
      ecc_h_q   <= '0;
      ecc_s_q   <= '0;
      data_q    <= '0;
      counter_q <= '0;
      done_q    <= 1'b0;
    end else begin
      slot_q <= data_island_period ? slot_q + 5'd1 : 5'd0;
      if (data_island_period) begin
        ecc_h_q <= ecc_h_d;
        ecc_s_q <= ecc_s_d;
      end
      if (packet_enable) begin
        hdr_q <= header;
        sub_q <= sub;
      end
      data_q    <= data_island_period ? data_d : 9'd0;
      counter_q <= data_island_period ? slot_q : 5'd0;
      done_q    <= data_island_period && (slot_q == 5'd31);
    end
  end

  assign packet_data = data_q;
  assign counter     = counter_q;
  assign packet_done = done_q;

`ifdef HDMI_PACKET_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (data_island_period && (slot_q == 5'd31)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign packet_count = count_q;
`endif

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
module tb_hdmi_packet_assembler;

  logic         clk_pixel = 1'b0;
  logic         reset_n;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [8:0]   packet_data;
  logic [4:0]   counter;
  logic         packet_enable;
  logic         packet_done;
`ifdef HDMI_PACKET_COUNT_EN
  logic [15:0]  packet_count;
`endif

  hdmi_packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_data        (packet_data),
    .counter            (counter),
    .packet_enable      (packet_enable),
    .packet_done        (packet_done)
`ifdef HDMI_PACKET_COUNT_EN
    ,
    .packet_count       (packet_count)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  // One packet with hand-computed parity; spar holds lane i parity at [8*i +: 8].
  typedef struct {
    logic [23:0]  hdr;
    logic [223:0] sub;
    logic [7:0]   hpar;
    logic [31:0]  spar;
  } vec_t;

  vec_t vecs [0:7];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected registered outputs for the next check point.
  logic [8:0] pend_data = '0;
  logic [4:0] pend_cnt  = '0;
  logic       pend_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_bits(input vec_t v, input int s);
    logic [8:0]  r;
    logic [55:0] w;
    logic [7:0]  p;
    r = '0;
    r[0] = (s < 24) ? v.hdr[s] : v.hpar[s-24];
    for (int i = 0; i < 4; i++) begin
      w = v.sub[56*i +: 56];
      p = v.spar[8*i +: 8];
      if (s < 28) begin
        r[1+i] = w[2*s];
        r[5+i] = w[2*s+1];
      end else begin
        r[1+i] = p[2*(s-28)];
        r[5+i] = p[2*(s-28)+1];
      end
    end
    return r;
  endfunction

  // One clock: check outputs registered at this edge, then drive this cycle's inputs.
  task automatic tick(input logic dip, input logic [23:0] h, input logic [223:0] s,
                      input logic exp_en, input logic [8:0] nd, input logic [4:0] nc,
                      input logic ndone);
    @(posedge clk_pixel);
    #2;
    check("packet_data", 32'(packet_data), 32'(pend_data));
    check("counter", 32'(counter), 32'(pend_cnt));
    check("packet_done", 32'(packet_done), 32'(pend_done));
    data_island_period = dip;
    header = h;
    sub = s;
    #1;
    check("packet_enable", 32'(packet_enable), 32'(exp_en));
    pend_data = nd;
    pend_cnt  = nc;
    pend_done = ndone;
  endtask

  task automatic idle();
    tick(1'b0, 24'h0, 224'h0, 1'b0, 9'h0, 5'd0, 1'b0);
  endtask

  task automatic run_packet(input int vi, input int n_slots, input bit mid_change);
    vec_t v;
    logic [23:0]  h;
    logic [223:0] sb;
    v = vecs[vi];
    for (int s = 0; s < n_slots; s++) begin
      h  = v.hdr;
      sb = v.sub;
      if (mid_change && s >= 10) begin
        h  = ~v.hdr;
        sb = ~v.sub;
      end
      tick(1'b1, h, sb, s == 0, exp_bits(v, s), 5'(s), s == 31);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].hdr  = '0;
      vecs[i].sub  = '0;
      vecs[i].hpar = '0;
      vecs[i].spar = '0;
    end
    vecs[1].hdr = 24'h800000; vecs[1].hpar = 8'h83;
    vecs[2].sub[55] = 1'b1;   vecs[2].spar = 32'h0000_0083;
    vecs[3].hdr = 24'h400000; vecs[3].hpar = 8'hC2;
    vecs[3].sub[110] = 1'b1;  vecs[3].spar = 32'h0000_C200;
    vecs[4].hdr = 24'hC00000; vecs[4].hpar = 8'h41;
    vecs[4].sub[166] = 1'b1;  vecs[4].sub[167] = 1'b1; vecs[4].spar = 32'h0041_0000;
    vecs[5].hdr = 24'h200000; vecs[5].hpar = 8'h61;
    vecs[5].sub[221] = 1'b1;  vecs[5].spar = 32'h6100_0000;
    vecs[6].hdr = 24'hC00000; vecs[6].hpar = 8'h41;
    vecs[6].sub[55] = 1'b1;   vecs[6].sub[110] = 1'b1;
    vecs[6].sub[166] = 1'b1;  vecs[6].sub[167] = 1'b1; vecs[6].sub[221] = 1'b1;
    vecs[6].spar = 32'h6141_C283;
    vecs[7].hdr = 24'h000001; vecs[7].hpar = 8'h4A;

    reset_n = 1'b0;
    data_island_period = 1'b0;
    header = '0;
    sub = '0;
    #3;
    check("reset packet_data", 32'(packet_data), 32'h0);
    check("reset counter", 32'(counter), 32'h0);
    check("reset packet_enable", 32'(packet_enable), 32'h0);
    check("reset packet_done", 32'(packet_done), 32'h0);
`ifdef HDMI_PACKET_COUNT_EN
    check("reset packet_count", 32'(packet_count), 32'h0);
`endif
    @(posedge clk_pixel);
    #2;
    reset_n = 1'b1;
    idle();
    idle();

    // Back-to-back packets with inputs scrambled from slot 10 onward.
    for (int v = 0; v < 8; v++) run_packet(v, 32, 1'b1);
    idle();
    idle();
`ifdef HDMI_PACKET_COUNT_EN
    check("packet_count after table", 32'(packet_count), 32'd8);
`endif

    // Abandon at slot 15, four idle cycles, then a fresh packet.
    run_packet(7, 15, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    run_packet(1, 32, 1'b0);
    idle();
`ifdef HDMI_PACKET_COUNT_EN
    check("packet_count after abort", 32'(packet_count), 32'd9);
`endif

    // Asynchronous reset pulsed at slot 20.
    run_packet(6, 20, 1'b0);
    @(posedge clk_pixel);
    #2;
    check("pre-reset packet_data", 32'(packet_data), 32'(pend_data));
    check("pre-reset counter", 32'(counter), 32'd19);
    reset_n = 1'b0;
    #1;
    check("async reset packet_data", 32'(packet_data), 32'h0);
    check("async reset counter", 32'(counter), 32'h0);
    check("async reset packet_enable", 32'(packet_enable), 32'h0);
    check("async reset packet_done", 32'(packet_done), 32'h0);
`ifdef HDMI_PACKET_COUNT_EN
    check("async reset packet_count", 32'(packet_count), 32'h0);
`endif
    data_island_period = 1'b0;
    reset_n = 1'b1;
    pend_data = '0;
    pend_cnt  = '0;
    pend_done = 1'b0;
    idle();
    run_packet(2, 32, 1'b0);
    idle();
    idle();
`ifdef HDMI_PACKET_COUNT_EN
    check("packet_count final", 32'(packet_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
